// File: rtl/batt_mon_if.sv
// Bundle that connects the battery monitor to its host: the enable, the A2D sample strobe,
// and the averaged result with its status flags.
interface batt_mon_if;
  logic        en;
  logic [11:0] batt;
  logic        batt_vld;
  logic [11:0] batt_avg;
  logic        avg_vld;
  logic        batt_low;
  logic        batt_crit;

  modport master (
    output en, batt, batt_vld,
    input  batt_avg, avg_vld, batt_low, batt_crit
  );

  modport slave (
    input  en, batt, batt_vld,
    output batt_avg, avg_vld, batt_low, batt_crit
  );
endinterface

// File: rtl/batt_mon.sv
// Battery monitor: averages A2D readings over blocks of 8 samples, then derives a debounced,
// hysteretic low-battery flag and a latched critical-battery flag from each average.
//
//   state | meaning
//   IDLE  | monitor disabled; window empty, strobes ignored
//   FILL  | collecting the first window since enable
//   RUN   | at least one average produced; windows continue back to back
module batt_mon #(
  parameter logic [11:0] LOW_THRESH  = 12'h800,
  parameter logic [11:0] HYST        = 12'h040,
  parameter logic [11:0] CRIT_THRESH = 12'h700,
  parameter int unsigned DEB         = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  batt_mon_if.slave     io_bus
);

  // Clear threshold saturates so a large HYST can never wrap below LOW_THRESH.
  localparam logic [12:0] CLR_SUM = {1'b0, LOW_THRESH} + {1'b0, HYST};
  localparam logic [11:0] CLR     = CLR_SUM[12] ? 12'hFFF : CLR_SUM[11:0];
  localparam logic [3:0]  DEB_TC  = 4'(DEB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_flush;
  logic        w_last;

  logic [14:0] r_acc;
  logic [2:0]  r_cnt;
  logic [14:0] w_sum;
  logic [11:0] r_avg;
  logic        r_avg_vld;

  logic        r_low;
  logic        r_crit;
  logic [3:0]  r_deb;
  logic        w_qual;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: begin
        w_flush = 1'b1;
        if (io_bus.en) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (!io_bus.en) begin
          w_flush     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_accept = io_bus.batt_vld;
          if (r_avg_vld) begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!io_bus.en) begin
          w_flush     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_accept = io_bus.batt_vld;
        end
      end
      default: begin
        w_flush     = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_last = w_accept && (r_cnt == 3'd7);
  // 8 x 12'hFFF = 15'h7FF8, so the 15-bit sum cannot overflow.
  assign w_sum  = r_acc + {3'b000, io_bus.batt};

  // The window clears on the same edge that publishes the average, so a strobe
  // during the avg_vld cycle lands as sample 1 of the next window.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc     <= 15'd0;
      r_cnt     <= 3'd0;
      r_avg     <= 12'h000;
      r_avg_vld <= 1'b0;
    end else begin
      r_avg_vld <= 1'b0;
      if (w_flush) begin
        r_acc <= 15'd0;
        r_cnt <= 3'd0;
      end else if (w_last) begin
        r_avg     <= w_sum[14:3];
        r_avg_vld <= 1'b1;
        r_acc     <= 15'd0;
        r_cnt     <= 3'd0;
      end else if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign w_qual = r_low ? (r_avg >= CLR) : (r_avg < LOW_THRESH);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_low  <= 1'b0;
      r_crit <= 1'b0;
      r_deb  <= 4'd0;
    end else if (!io_bus.en) begin
      r_low  <= 1'b0;
      r_crit <= 1'b0;
      r_deb  <= 4'd0;
    end else if (r_avg_vld) begin
      if (r_avg < CRIT_THRESH) begin
        r_crit <= 1'b1;
      end
      if (!w_qual) begin
        r_deb <= 4'd0;
      end else if ((r_deb + 4'd1) == DEB_TC) begin
        r_deb <= 4'd0;
        r_low <= ~r_low;
      end else begin
        r_deb <= r_deb + 4'd1;
      end
    end
  end

  assign io_bus.batt_avg  = r_avg;
  assign io_bus.avg_vld   = r_avg_vld;
  assign io_bus.batt_low  = r_low;
  assign io_bus.batt_crit = r_crit;

endmodule

// File: tb/tb_batt_mon.sv
// Testbench for batt_mon: directed scenarios with literal expectations plus a long
// randomized run, all outputs compared every cycle against a sample-queue model.
module tb_batt_mon;

  localparam logic [11:0] LOW_THRESH  = 12'h800;
  localparam logic [11:0] HYST        = 12'h040;
  localparam logic [11:0] CRIT_THRESH = 12'h700;
  localparam int          DEB         = 3;
  localparam int          CLR         = (int'(LOW_THRESH) + int'(HYST) > 4095) ? 4095
                                        : int'(LOW_THRESH) + int'(HYST);

  logic clk;
  logic rst_n;
  batt_mon_if bus ();

  batt_mon #(
    .LOW_THRESH (LOW_THRESH),
    .HYST       (HYST),
    .CRIT_THRESH(CRIT_THRESH),
    .DEB        (DEB)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;
  int cyc         = 0;

  // Model state: sample queue of the open window plus the published results.
  bit          m_active;
  int          m_q[$];
  logic [11:0] m_avg;
  bit          m_vld;
  bit          m_low;
  bit          m_crit;
  int          m_run;
  bit          m_pend;
  int          m_sum;
  int          m_a;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 0;
      m_q.delete();
      m_avg    = 12'h000;
      m_vld    = 0;
      m_low    = 0;
      m_crit   = 0;
      m_run    = 0;
    end else if (!bus.en) begin
      m_active = 0;
      m_q.delete();
      m_vld    = 0;
      m_low    = 0;
      m_crit   = 0;
      m_run    = 0;
    end else begin
      m_pend = m_vld;
      m_a    = int'(m_avg);
      m_vld  = 0;
      if (m_pend) begin
        if (m_a < int'(CRIT_THRESH)) m_crit = 1;
        if (m_low ? (m_a >= CLR) : (m_a < int'(LOW_THRESH))) m_run++;
        else m_run = 0;
        if (m_run == DEB) begin
          m_low = !m_low;
          m_run = 0;
        end
      end
      if (m_active && bus.batt_vld) begin
        m_q.push_back(int'(bus.batt));
        if (m_q.size() == 8) begin
          m_sum = 0;
          foreach (m_q[k]) m_sum += m_q[k];
          m_avg = 12'(m_sum / 8);
          m_vld = 1;
          m_q.delete();
        end
      end
      m_active = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ({bus.batt_avg, bus.avg_vld, bus.batt_low, bus.batt_crit} !==
          {m_avg, m_vld, m_low, m_crit}) begin
        miscompares++;
        $display("FAIL model cycle %0d: dut avg=%h vld=%b low=%b crit=%b, model avg=%h vld=%b low=%b crit=%b",
                 cyc, bus.batt_avg, bus.avg_vld, bus.batt_low, bus.batt_crit,
                 m_avg, m_vld, m_low, m_crit);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic [11:0] b);
    bus.en       = en;
    bus.batt_vld = vld;
    bus.batt     = b;
    @(negedge clk);
  endtask

  // Eight strobes of one value, then a quiet cycle so the flags have settled.
  task automatic window(input logic [11:0] v, input string nm);
    int early = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, v);
      if (i < 7 && bus.avg_vld) early++;
    end
    check({nm, "_early_vld"}, early, 0);
    check({nm, "_vld"}, int'(bus.avg_vld), 1);
    check({nm, "_avg"}, int'(bus.batt_avg), int'(v));
    drive(1'b1, 1'b0, 12'h000);
  endtask

  logic [11:0] lv[8] = '{12'h6F0, 12'h7F0, 12'h800, 12'h820,
                         12'h840, 12'h900, 12'hFFF, 12'h000};

  initial begin
    int pulses;
    int pos[$];
    logic [11:0] base;
    logic [11:0] b;

    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.batt_vld = 1'b0;
    bus.batt     = 12'h000;
    drive(1'b0, 1'b0, 12'h000);
    drive(1'b0, 1'b0, 12'h000);
    chk_en = 1'b1;
    check("rst_avg",  int'(bus.batt_avg),  0);
    check("rst_vld",  int'(bus.avg_vld),   0);
    check("rst_low",  int'(bus.batt_low),  0);
    check("rst_crit", int'(bus.batt_crit), 0);

    rst_n = 1'b1;
    drive(1'b1, 1'b0, 12'h000);
    window(12'h900, "avg900");
    check("avg900_low",  int'(bus.batt_low),  0);
    check("avg900_crit", int'(bus.batt_crit), 0);
    window(12'hFFF, "avgFFF");

    for (int i = 0; i < 3; i++) begin
      window(12'h7F0, "set7F0");
      check("set7F0_low", int'(bus.batt_low), (i == 2) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      window(12'h820, "hold820");
      check("hold820_low", int'(bus.batt_low), 1);
    end
    for (int i = 0; i < 3; i++) begin
      window(12'h840, "clr840");
      check("clr840_low", int'(bus.batt_low), (i == 2) ? 0 : 1);
    end
    for (int i = 0; i < 3; i++) begin
      window(12'h800, "eq800");
      check("eq800_low", int'(bus.batt_low), 0);
    end
    for (int i = 0; i < 3; i++) window(12'h7F0, "reset7F0");
    check("reset7F0_low", int'(bus.batt_low), 1);
    window(12'h840, "pat1");
    window(12'h820, "pat2");
    window(12'h840, "pat3");
    window(12'h840, "pat4");
    check("pattern_low", int'(bus.batt_low), 1);

    window(12'h6FF, "crit6FF");
    check("crit6FF_crit", int'(bus.batt_crit), 1);
    window(12'hA00, "critA00");
    check("critA00_crit", int'(bus.batt_crit), 1);
    drive(1'b0, 1'b0, 12'h000);
    check("en_off_crit", int'(bus.batt_crit), 0);
    check("en_off_low",  int'(bus.batt_low),  0);

    drive(1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 12'h123);
    drive(1'b0, 1'b0, 12'h000);
    drive(1'b1, 1'b0, 12'h000);
    window(12'hA00, "abort_en");

    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 12'h456);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 12'h000);
    check("abort_rst_avg0", int'(bus.batt_avg), 0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 12'h000);
    window(12'hA00, "abort_rst");

    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 12'($urandom));
      if (bus.avg_vld) begin
        pulses++;
        pos.push_back(i);
      end
    end
    check("b2b_pulses", pulses, 2);
    if (pos.size() == 2) begin
      check("b2b_first", pos[0], 7);
      check("b2b_gap", pos[1] - pos[0], 8);
    end
    drive(1'b1, 1'b0, 12'h000);

    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 12'h555);
    drive(1'b0, 1'b1, 12'h555);
    check("en_fall_no_vld", int'(bus.avg_vld), 0);
    drive(1'b1, 1'b0, 12'h000);
    window(12'h321, "after_fall");

    base = 12'h900;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) base = lv[$urandom_range(0, 7)];
      b = ($urandom_range(0, 7) == 0) ? 12'($urandom) : base;
      drive(($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)), b);
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 12'h000);
    drive(1'b1, 1'b0, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
